// File: rtl/digdar_capture_pkg.sv
// digdar_capture shared types: FSM state encoding
// and the power-of-two rate helper.
package digdar_capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int KMAX = 16;

  // {is 2^k with k<=KMAX, k}
  function automatic logic [5:0] pow2_log(input logic [31:0] d);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i <= KMAX; i++)
      if (d == (32'd1 << i)) r = {1'b1, 5'(i)};
    return r;
  endfunction

endpackage

// File: rtl/digdar_dec_avg.sv
// Per-channel decimator / averager; the window
// counter lives in the parent and is shared.
module digdar_dec_avg
  import digdar_capture_pkg::*;
#(
  parameter int DW   = 16,
  parameter int DECW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          first,
  input  logic          last,
  input  logic          avg,
  input  logic [4:0]    shift,
  input  logic [DW-1:0] samp,
  output logic [DW-1:0] dat,
  output logic          strobe
);

  localparam int SW = DW + DECW;

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] ext;
  logic signed [SW-1:0] acc;
  logic        [DW-1:0] avgd;

  // first sample of a window seeds the sum
  assign ext  = {{DECW{samp[DW-1]}}, samp};
  assign acc  = first ? ext : sum + ext;
  assign avgd = DW'(acc >>> shift);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum    <= '0;
      dat    <= '0;
      strobe <= 1'b0;
    end else begin
      sum    <= acc;
      strobe <= last;
      if (last) dat <= avg ? avgd : samp;
    end
  end

endmodule

// File: rtl/digdar_capture.sv
// Multi-channel decimating ring capture with pre-trigger.
// Optional DIGDAR_CAPTURE_COUNT_EN: ch0 test counter.
module digdar_capture
  import digdar_capture_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int DW   = 16,
  parameter int AW   = 14,
  parameter int DECW = 17
) (
  input  logic                     adc_clk_i,
  input  logic                     adc_rst_i,
  input  logic [NCH*DW-1:0]        samp_i,
  input  logic                     trig_i,
  input  logic                     arm_i,
  input  logic                     abort_i,
  input  logic [DECW-1:0]          cfg_dec_i,
  input  logic                     cfg_avg_i,
  input  logic [AW-1:0]            cfg_pre_i,
  input  logic [AW:0]              cfg_size_i,
`ifdef DIGDAR_CAPTURE_COUNT_EN
  input  logic                     cfg_count_i,
`endif
  input  logic                     rd_en_i,
  input  logic [$clog2(NCH)-1:0]   rd_ch_i,
  input  logic [AW-1:0]            rd_addr_i,
  output logic [DW-1:0]            rd_data_o,
  output logic                     rd_valid_o,
  output logic [2:0]               state_o,
  output logic                     capturing_o,
  output logic                     done_o,
  output logic [AW-1:0]            trig_pos_o
);

  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH = PW'(2**AW);

  state_t            state;
  logic [DECW-1:0]   dec_q, dec_m1, cnt;
  logic              avg_q, avg_en;
  logic [5:0]        plog;
  logic [PW-1:0]     pre_q, size_q, pre_cnt, post_cnt;
  logic [PW-1:0]     size_c, pre_ext, pre_c, pre_nx;
  logic [AW-1:0]     wp;
  logic              clr, first, last, wr;
  logic [NCH-1:0]    strb;
  logic [DW-1:0]     ch0;
  logic [NCH*DW-1:0] rd_all;
  logic              v1;
  logic [$clog2(NCH)-1:0] ch_q;

  assign state_o = state;
  assign clr     = arm_i & ~abort_i;

  assign size_c  = (cfg_size_i > DEPTH) ? DEPTH :
                   (cfg_size_i == '0) ? PW'(1) : cfg_size_i;
  assign pre_ext = PW'(cfg_pre_i);
  assign pre_c   = (pre_ext >= size_c) ? size_c - PW'(1) : pre_ext;

  assign plog    = pow2_log(32'(dec_q));
  assign avg_en  = avg_q & plog[5];
  assign dec_m1  = (dec_q <= DECW'(1)) ? '0 : dec_q - DECW'(1);
  assign first   = (cnt == '0);
  assign last    = (cnt == dec_m1);

  assign wr      = (|strb) & capturing_o;
  assign pre_nx  = pre_cnt + PW'(wr);

`ifdef DIGDAR_CAPTURE_COUNT_EN
  logic [DW-1:0] ramp;
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) ramp <= '0;
    else           ramp <= ramp + DW'(1);
  end
  assign ch0 = cfg_count_i ? ramp : samp_i[DW-1:0];
`else
  assign ch0 = samp_i[DW-1:0];
`endif

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i || clr) cnt <= '0;
    else if (last)        cnt <= '0;
    else                  cnt <= cnt + DECW'(1);
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DW-1:0] din, dat, q;
    logic          stb;
    logic [DW-1:0] mem [2**AW];

    if (c == 0) begin : g_c0
      assign din = ch0;
    end else begin : g_cn
      assign din = samp_i[c*DW +: DW];
    end

    digdar_dec_avg #(.DW(DW), .DECW(DECW)) u_dec (
      .clk    (adc_clk_i),
      .rst    (adc_rst_i),
      .clr    (clr),
      .first  (first),
      .last   (last),
      .avg    (avg_en),
      .shift  (plog[4:0]),
      .samp   (din),
      .dat    (dat),
      .strobe (stb)
    );

    assign strb[c] = stb;

    // read-first: q sees the pre-write word
    always_ff @(posedge adc_clk_i) begin
      if (wr)      mem[wp] <= dat;
      if (rd_en_i) q <= mem[rd_addr_i];
    end

    assign rd_all[c*DW +: DW] = q;
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      v1         <= 1'b0;
      ch_q       <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      v1         <= rd_en_i;
      if (rd_en_i) ch_q <= rd_ch_i;
      rd_valid_o <= v1;
      if (v1) rd_data_o <= rd_all[ch_q*DW +: DW];
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      state       <= S_IDLE;
      capturing_o <= 1'b0;
      done_o      <= 1'b0;
      trig_pos_o  <= '0;
      wp          <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      dec_q       <= '0;
      avg_q       <= 1'b0;
      pre_q       <= '0;
      size_q      <= '0;
    end else if (abort_i) begin
      state       <= S_IDLE;
      capturing_o <= 1'b0;
      done_o      <= 1'b0;
    end else if (arm_i) begin
      state       <= S_PRE;
      capturing_o <= 1'b1;
      done_o      <= 1'b0;
      wp          <= '0;
      pre_cnt     <= '0;
      dec_q       <= cfg_dec_i;
      avg_q       <= cfg_avg_i;
      pre_q       <= pre_c;
      size_q      <= size_c;
    end else begin
      if (wr) wp <= wp + AW'(1);
      unique case (state)
        S_PRE: begin
          pre_cnt <= pre_nx;
          if (pre_nx >= pre_q) state <= S_ARMED;
        end
        // first post-trigger sample lands at the next write slot
        S_ARMED: if (trig_i) begin
          trig_pos_o <= wp + AW'(wr);
          post_cnt   <= size_q - pre_q;
          state      <= S_POST;
        end
        S_POST: if (wr) begin
          post_cnt <= post_cnt - PW'(1);
          if (post_cnt == PW'(1)) begin
            state       <= S_DONE;
            capturing_o <= 1'b0;
            done_o      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digdar_capture.sv
// Directed bench for digdar_capture (NCH=2, DW=16, AW=4).
module tb_digdar_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] samp = '0;
  logic        trig = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [16:0] dec = 17'd1;
  logic        avg = 1'b0;
  logic [3:0]  pre = '0;
  logic [4:0]  size = 5'd8;
  logic        rd_en = 1'b0;
  logic        rd_ch = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [2:0]  state;
  logic        capturing;
  logic        done;
  logic [3:0]  trig_pos;
  logic [15:0] d;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  digdar_capture #(.NCH(2), .DW(16), .AW(4), .DECW(17)) dut (
    .adc_clk_i   (clk),
    .adc_rst_i   (rst),
    .samp_i      (samp),
    .trig_i      (trig),
    .arm_i       (arm),
    .abort_i     (abort),
    .cfg_dec_i   (dec),
    .cfg_avg_i   (avg),
    .cfg_pre_i   (pre),
    .cfg_size_i  (size),
`ifdef DIGDAR_CAPTURE_COUNT_EN
    .cfg_count_i (1'b0),
`endif
    .rd_en_i     (rd_en),
    .rd_ch_i     (rd_ch),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .state_o     (state),
    .capturing_o (capturing),
    .done_o      (done),
    .trig_pos_o  (trig_pos)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic rd(input int ch, input int addr, output logic [15:0] q);
    rd_en   = 1'b1;
    rd_ch   = 1'(ch);
    rd_addr = 4'(addr);
    step();
    rd_en = 1'b0;
    chk("rd_early", 32'(rd_valid), 32'd0);
    step();
    chk("rd_valid", 32'(rd_valid), 32'd1);
    q = rd_data;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cap", 32'(capturing), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tpos", 32'(trig_pos), 32'd0);
    chk("rst_rdv", 32'(rd_valid), 32'd0);
    chk("rst_rdd", 32'(rd_data), 32'd0);
    rst = 1'b0;
    step();

    // pre-trigger capture: ramp 100.., trig on 6th sample
    dec = 17'd1; avg = 1'b0; pre = 4'd3; size = 5'd8;
    do_arm();
    chk("t1_arm_state", 32'(state), 32'd1);
    chk("t1_arm_cap", 32'(capturing), 32'd1);
    for (int i = 0; i <= 10; i++) begin
      samp = {16'd0, 16'(100 + i)};
      trig = (i == 5);
      step();
      trig = 1'b0;
      if (i == 2) chk("t1_still_pre", 32'(state), 32'd1);
      if (i == 3) chk("t1_armed", 32'(state), 32'd2);
      if (i == 5) begin
        chk("t1_post", 32'(state), 32'd3);
        chk("t1_tpos", 32'(trig_pos), 32'd5);
      end
    end
    chk("t1_done_state", 32'(state), 32'd4);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_cap_off", 32'(capturing), 32'd0);
    for (int j = 0; j < 8; j++) begin
      rd(0, 2 + j, d);
      chk("t1_data", 32'(d), 32'(102 + j));
    end
    rd_en = 1'b1; rd_ch = 1'b0; rd_addr = 4'd5;
    step();
    rd_addr = 4'd6;
    step();
    chk("b2b_v0", 32'(rd_valid), 32'd1);
    chk("b2b_d0", 32'(rd_data), 32'd105);
    rd_en = 1'b0;
    step();
    chk("b2b_v1", 32'(rd_valid), 32'd1);
    chk("b2b_d1", 32'(rd_data), 32'd106);
    step();
    chk("b2b_idle", 32'(rd_valid), 32'd0);

    // averaging over 4: -8 x4 then +8 x4, ch1 constant 300
    dec = 17'd4; avg = 1'b1; pre = 4'd0; size = 5'd16;
    do_arm();
    for (int i = 0; i < 10; i++) begin
      samp = {16'd300, (i < 4) ? 16'hfff8 : 16'h0008};
      step();
    end
    chk("avg_state", 32'(state), 32'd2);
    rd(0, 0, d);
    chk("avg_w0", 32'(d), 32'h0000fff8);
    rd(0, 1, d);
    chk("avg_w1", 32'(d), 32'h00000008);
    rd(1, 0, d);
    chk("avg_ch1", 32'(d), 32'd300);

    // rate 3 is not a power of two: raw every 3rd sample
    dec = 17'd3; avg = 1'b1; pre = 4'd0; size = 5'd16;
    do_arm();
    for (int i = 0; i < 10; i++) begin
      samp = {16'd0, 16'(200 + i)};
      step();
    end
    for (int j = 0; j < 3; j++) begin
      rd(0, j, d);
      chk("dec3", 32'(d), 32'(202 + 3 * j));
    end

    // wrap: size 31->16, pre 15, trigger at sample 20
    dec = 17'd1; avg = 1'b0; pre = 4'd15; size = 5'd31;
    do_arm();
    for (int i = 0; i <= 21; i++) begin
      samp = {16'd0, 16'(500 + i)};
      trig = (i == 20);
      step();
      trig = 1'b0;
      if (i == 14) chk("wr_pre", 32'(state), 32'd1);
      if (i == 15) chk("wr_armed", 32'(state), 32'd2);
      if (i == 20) begin
        chk("wr_post", 32'(state), 32'd3);
        chk("wr_tpos", 32'(trig_pos), 32'd4);
      end
      if (i == 21) chk("wr_done", 32'(state), 32'd4);
    end
    rd(0, 5, d);
    chk("wr_oldest", 32'(d), 32'd505);
    rd(0, 4, d);
    chk("wr_first_post", 32'(d), 32'd520);
    rd(0, 3, d);
    chk("wr_last_pre", 32'(d), 32'd519);

    // clamp: size 0 -> 1, pre 5 -> 0
    pre = 4'd5; size = 5'd0;
    do_arm();
    for (int i = 0; i <= 4; i++) begin
      samp = {16'd0, 16'(i)};
      trig = (i == 3);
      step();
      trig = 1'b0;
      if (i == 0) chk("cl_armed", 32'(state), 32'd2);
      if (i == 3) begin
        chk("cl_post", 32'(state), 32'd3);
        chk("cl_tpos", 32'(trig_pos), 32'd3);
      end
      if (i == 4) chk("cl_done", 32'(state), 32'd4);
    end

    // collisions
    pre = 4'd0; size = 5'd4;
    do_arm();
    step();
    chk("co_armed", 32'(state), 32'd2);
    arm = 1'b1; trig = 1'b1;
    step();
    arm = 1'b0; trig = 1'b0;
    chk("co_arm_wins", 32'(state), 32'd1);
    chk("co_tpos_kept", 32'(trig_pos), 32'd3);
    step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    chk("co_post", 32'(state), 32'd3);
    chk("co_tpos", 32'(trig_pos), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_state", 32'(state), 32'd0);
    chk("ab_cap", 32'(capturing), 32'd0);
    abort = 1'b1; arm = 1'b1;
    step();
    abort = 1'b0; arm = 1'b0;
    chk("ab_over_arm", 32'(state), 32'd0);

    // reset during POST
    size = 5'd8;
    do_arm();
    step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    chk("mr_post", 32'(state), 32'd3);
    rd_en = 1'b1; rd_ch = 1'b0; rd_addr = 4'd0;
    step();
    rd_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_state", 32'(state), 32'd0);
    chk("mr_cap", 32'(capturing), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_tpos", 32'(trig_pos), 32'd0);
    chk("mr_rdv", 32'(rd_valid), 32'd0);
    chk("mr_rdd", 32'(rd_data), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
